// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants.
// Used by the fetch stage and its fetch buffer.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: IMEM address/data, redirect and decode handshake.
// master = fetch unit, slave = IMEM/decode environment.
interface fetch_unit_if;
  import rv32i_pkg::*;

  logic [XLEN-1:0] instr_addr;
  logic [XLEN-1:0] instr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic            misalign_err;

  modport master (
    output instr_addr, id_valid, id_instr,
    output id_pc, id_pc_plus4, misalign_err,
    input  instr_rdata, redirect_valid,
    input  redirect_pc, id_ready
  );

  modport slave (
    input  instr_addr, id_valid, id_instr,
    input  id_pc, id_pc_plus4, misalign_err,
    output instr_rdata, redirect_valid,
    output redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry circular FIFO of {pc, instr}.
// Flush dominates push and pop.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = din;
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fills the fetch buffer
// from IMEM and hands {pc, instr} to decode via valid/ready.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            push, pop, full, empty;
  logic            id_valid;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] id_pc;
  fetch_entry_t    din, dout;

  assign id_valid = |count;
  assign pop      = id_valid & bus.id_ready;
  assign push     = !bus.redirect_valid & (!full | pop);

  always_comb begin
    din       = '0;
    din.pc    = pc_q;
    din.instr = bus.instr_rdata;
  end

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    unique case (1'b1)
      bus.redirect_valid: pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      push:               pc_d = pc_q + 32'd4;
      default:            ;
    endcase
    // Sticky until reset; aligned redirects never clear it.
    if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
      misalign_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // An empty buffer shows the next PC to be fetched with a NOP.
  assign id_pc            = empty ? pc_q : dout.pc;
  assign bus.instr_addr   = pc_q;
  assign bus.id_valid     = id_valid;
  assign bus.id_instr     = empty ? NOP_INSTR : dout.instr;
  assign bus.id_pc        = id_pc;
  assign bus.id_pc_plus4  = id_pc + 32'd4;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// Two instances: RESET_PC = 0 and RESET_PC = 32'hFFFF_FFF8.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic rst2_n;
  logic [31:0] imem [64];
  int n_run;
  int n_fail;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  assign bus.instr_rdata  = imem[bus.instr_addr[7:2]];
  assign bus2.instr_rdata = imem[bus2.instr_addr[7:2]];

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    if (bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0", bus.id_valid);
    end
    n_run++;
    if (bus.id_instr !== 32'h0000_0013) begin
      n_fail++; $display("FAIL reset_instr got %h exp 00000013", bus.id_instr);
    end
    n_run++;
    if (bus.id_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc got %h exp 0", bus.id_pc);
    end
    n_run++;
    if (bus.id_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL reset_pc4 got %h exp 4", bus.id_pc_plus4);
    end
    n_run++;
    if (bus.instr_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr got %h exp 0", bus.instr_addr);
    end
    n_run++;
    if (bus.misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_misalign got %b exp 0", bus.misalign_err);
    end
    n_run++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h0031_0093;
    exp_i[1] = 32'hFFD2_8113;
    exp_i[2] = 32'h0094_4493;
    bus.id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.id_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.id_valid);
      end
      n_run++;
      if (bus.id_instr !== exp_i[i]) begin
        n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, bus.id_instr, exp_i[i]);
      end
      n_run++;
      if (bus.id_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.id_pc, 32'(4 * i));
      end
      n_run++;
      if (bus.id_pc_plus4 !== 32'(4 * i + 4)) begin
        n_fail++; $display("FAIL stream_pc4[%0d] got %h exp %h", i, bus.id_pc_plus4, 32'(4 * i + 4));
      end
      n_run++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h0031_0093;
    exp_i[1] = 32'hFFD2_8113;
    exp_i[2] = 32'h0094_4493;
    exp_i[3] = 32'hA000_0003;
    bus.id_ready = 1'b0;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    if (bus.instr_addr !== 32'h8) begin
      n_fail++; $display("FAIL bp_hold_addr got %h exp 8", bus.instr_addr);
    end
    n_run++;
    if (bus.id_instr !== exp_i[0] || bus.id_pc !== 32'h0) begin
      n_fail++; $display("FAIL bp_hold_head got %h@%h exp %h@0", bus.id_instr, bus.id_pc, exp_i[0]);
    end
    n_run++;
    if (bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold_valid got %b exp 1", bus.id_valid);
    end
    n_run++;
    bus.id_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.id_pc !== 32'(4 * i) || bus.id_instr !== exp_i[i]) begin
        n_fail++; $display("FAIL bp_drain[%0d] got %h@%h exp %h@%h", i, bus.id_instr, bus.id_pc, exp_i[i], 32'(4 * i));
      end
      n_run++;
      if (bus.instr_addr !== 32'(8 + 4 * i)) begin
        n_fail++; $display("FAIL bp_addr[%0d] got %h exp %h", i, bus.instr_addr, 32'(8 + 4 * i));
      end
      n_run++;
    end
  endtask

  task automatic test_full_stream();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(16 + 4 * k)) begin
        n_fail++; $display("FAIL full_pc[%0d] got v%b %h exp v1 %h", k, bus.id_valid, bus.id_pc, 32'(16 + 4 * k));
      end
      n_run++;
      if (bus.id_instr !== 32'(32'hA000_0004 + k)) begin
        n_fail++; $display("FAIL full_instr[%0d] got %h exp %h", k, bus.id_instr, 32'(32'hA000_0004 + k));
      end
      n_run++;
      if (bus.instr_addr !== 32'(24 + 4 * k)) begin
        n_fail++; $display("FAIL full_addr[%0d] got %h exp %h", k, bus.instr_addr, 32'(24 + 4 * k));
      end
      n_run++;
    end
  endtask

  task automatic test_redirect();
    bus.redirect_pc    = 32'h20;
    bus.redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0000_0013) begin
      n_fail++; $display("FAIL redir_flush got v%b %h exp v0 00000013", bus.id_valid, bus.id_instr);
    end
    n_run++;
    if (bus.instr_addr !== 32'h20) begin
      n_fail++; $display("FAIL redir_addr got %h exp 20", bus.instr_addr);
    end
    n_run++;
    @(posedge clk);
    #1;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h20) begin
      n_fail++; $display("FAIL redir_head got v%b %h exp v1 20", bus.id_valid, bus.id_pc);
    end
    n_run++;
    if (bus.id_instr !== 32'h0031_2013) begin
      n_fail++; $display("FAIL redir_instr got %h exp 00312013", bus.id_instr);
    end
    n_run++;
    if (bus.id_pc_plus4 !== 32'h24 || bus.misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL redir_pc4 got %h m%b exp 24 m0", bus.id_pc_plus4, bus.misalign_err);
    end
    n_run++;
  endtask

  task automatic test_misalign();
    bus.redirect_pc    = 32'h13;
    bus.redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    if (bus.instr_addr !== 32'h10 || bus.misalign_err !== 1'b1) begin
      n_fail++; $display("FAIL mis_set got %h m%b exp 10 m1", bus.instr_addr, bus.misalign_err);
    end
    n_run++;
    repeat (10) @(posedge clk);
    #1;
    if (bus.misalign_err !== 1'b1) begin
      n_fail++; $display("FAIL mis_sticky got %b exp 1", bus.misalign_err);
    end
    n_run++;
    bus.redirect_pc    = 32'h40;
    bus.redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    if (bus.instr_addr !== 32'h40 || bus.misalign_err !== 1'b1) begin
      n_fail++; $display("FAIL mis_aligned got %h m%b exp 40 m1", bus.instr_addr, bus.misalign_err);
    end
    n_run++;
    rst_n = 1'b0;
    #1;
    if (bus.misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_clear got %b exp 0", bus.misalign_err);
    end
    n_run++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.id_ready = 1'b0;
    do_reset();
    repeat (3) @(posedge clk);
    #2;
    if (bus.id_valid !== 1'b1 || bus.instr_addr !== 32'h8) begin
      n_fail++; $display("FAIL arst_pre got v%b %h exp v1 8", bus.id_valid, bus.instr_addr);
    end
    n_run++;
    rst_n = 1'b0;
    #1;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0000_0013) begin
      n_fail++; $display("FAIL arst_flush got v%b %h exp v0 00000013", bus.id_valid, bus.id_instr);
    end
    n_run++;
    if (bus.instr_addr !== 32'h0) begin
      n_fail++; $display("FAIL arst_addr got %h exp 0", bus.instr_addr);
    end
    n_run++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_i [3];
    logic [31:0] exp_p4 [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_i[0] = 32'hA000_003E; exp_p4[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'hFFFF_FFFC; exp_i[1] = 32'hA000_003F; exp_p4[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0000; exp_i[2] = 32'h0031_0093; exp_p4[2] = 32'h0000_0004;
    if (bus2.instr_addr !== 32'hFFFF_FFF8 || bus2.id_pc_plus4 !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_reset got %h/%h exp fffffff8/fffffffc", bus2.instr_addr, bus2.id_pc_plus4);
    end
    n_run++;
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus2.id_valid !== 1'b1 || bus2.id_pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL wrap_pc[%0d] got v%b %h exp v1 %h", i, bus2.id_valid, bus2.id_pc, exp_pc[i]);
      end
      n_run++;
      if (bus2.id_instr !== exp_i[i] || bus2.id_pc_plus4 !== exp_p4[i]) begin
        n_fail++; $display("FAIL wrap_data[%0d] got %h/%h exp %h/%h", i, bus2.id_instr, bus2.id_pc_plus4, exp_i[i], exp_p4[i]);
      end
      n_run++;
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 + 32'(i);
    imem[0] = 32'h0031_0093;
    imem[1] = 32'hFFD2_8113;
    imem[2] = 32'h0094_4493;
    imem[8] = 32'h0031_2013;
    bus.id_ready        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus2.id_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_stream();
    test_redirect();
    test_misalign();
    test_async_reset();
    test_reset_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of IMEM.
- Owns the program counter and drives the IMEM word address each cycle.
- Captures the combinational IMEM read data into a small fetch buffer.
- Presents {pc, instr} to decode through a valid/ready handshake, so decode back-pressure stalls fetch without losing instructions.
- Accepts a redirect (branch/jump target) that flushes buffered instructions and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, fetch-buffer entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- instr_addr  output  32  byte address to IMEM; equals pc register.
- instr_rdata  input  32  IMEM combinational read data for instr_addr.
- redirect_valid  input  1  load redirect_pc and flush this cycle.
- redirect_pc  input  32  redirect target byte address.
- id_ready  input  1  decode accepts head entry this cycle.
- id_valid  output  1  head entry valid.
- id_instr  output  32  head instruction.
- id_pc  output  32  head instruction's PC.
- id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
- misalign_err  output  1  sticky flag: a redirect target had bits [1:0] ≠ 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC; buffer count = 0; read and write pointers = 0; misalign_err = 0.
  - id_valid = 0; id_instr = 32'h0000_0013 (NOP); id_pc = RESET_PC; id_pc_plus4 = RESET_PC + 4.
  - A reset asserted mid-operation discards all buffered entries immediately.
- instr_addr = pc, a registered value with no combinational path from any input.
- pop = id_valid & id_ready.
- push = !redirect_valid & (count < DEPTH | pop). Push and pop in the same cycle are legal when full.
- On push:
  - Buffer[wptr] <= {pc, instr_rdata}; wptr <= wptr + 1, wrapping at DEPTH.
  - pc <= pc + 4; wraps 32'hFFFF_FFFC → 32'h0000_0000.
- On pop: rptr <= rptr + 1, wrapping.
- count update: count + push − pop, held in $clog2(DEPTH)+1 bits.
- When full with no pop: pc holds; instr_addr is stable and is re-read next cycle.
- Redirect has priority over push and pop:
  - count <= 0; rptr <= wptr <= 0; pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle. A pop in the same cycle is not considered accepted; decode must ignore the head while redirect_valid is high.
  - If redirect_pc[1:0] ≠ 0, misalign_err <= 1 and stays set until reset.
- id_valid = (count ≠ 0). id_instr and id_pc come from Buffer[rptr]. When count = 0, id_instr = NOP.
- Latency:
  - Instruction at pc is visible on id_* one cycle after it is addressed.
  - After reset release, first rising edge pushes mem[RESET_PC>>2]; id_valid is high after that edge.
  - After redirect, the first target instruction appears 2 edges after the redirect edge: the load-pc edge, then the push edge.
- Steady state with id_ready held high: one instruction per cycle, no bubbles.
- redirect_valid while count = 0: same flush/reload action; harmless.

Decomposition:
- Package rv32i_pkg:
  - XLEN = 32; NOP_INSTR = 32'h0000_0013.
  - Typedef fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH, storing fetch_entry_t.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - fetch_unit keeps pc, redirect and misalign logic at top level.

Test Plan:
1. Reset release, id_ready = 1, IMEM preloaded with 00310093, FFD28113, 00944493 → id_* sequence (00310093, pc 0), (FFD28113, pc 4), (00944493, pc 8) on consecutive cycles; id_pc_plus4 = 4, 8, 12.
2. id_ready = 0 for 4 cycles after reset → count saturates at 2, pc holds at 8, id_instr stays 00310093. Raise id_ready → pc 0, 4, 8 delivered in order with none dropped or duplicated.
3. Full buffer with id_ready = 1 → simultaneous push/pop each cycle; count stays 2; pc advances by 4 per cycle.
4. redirect_valid with redirect_pc = 32'h20 while count = 2 → next cycle id_valid = 0 and instr_addr = 32'h20. Following cycle id_pc = 32'h20 with instr = mem[8] = 00312013.
5. redirect_pc = 32'h0000_0013 → pc = 32'h10; misalign_err = 1 and stays set across 10 cycles and further aligned redirects. Cleared only by rst_n low.
6. rst_n pulsed low asynchronously (between clock edges) mid-stream with count = 2 → id_valid falls within the same cycle, instr_addr = RESET_PC. RESET_PC = 32'hFFFF_FFF8 → fetch at FFFF_FFF8, FFFF_FFFC, then 0000_0000.
